// File: rtl/sasa_block_scheduler.sv
// rtl/sasa_block_scheduler.sv - diagonal block sequencer for the SASA attention engine
// Per block: QK fetch over a valid/ready port, then CAM1 and CAM2 phases under a watchdog.
module sasa_block_scheduler #(
  parameter int SEQ_LEN = 16,
  parameter int BLK_WID = 4,
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = $clog2(SEQ_LEN),
  parameter int BLK_W   = (SEQ_LEN / BLK_WID > 1) ? $clog2(SEQ_LEN / BLK_WID) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [BLK_W-1:0]  blk_idx_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [ADDR_W-1:0] rd_addr_x_o,
  output logic [ADDR_W-1:0] rd_addr_y_o,
  output logic              rd_last_o,
  output logic              cam1_start_o,
  input  logic              cam1_done_i,
  output logic              cam2_start_o,
  input  logic              cam2_done_i
);

  localparam int NBLK = SEQ_LEN / BLK_WID;
  localparam int RC_W = (BLK_WID > 1) ? $clog2(BLK_WID) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(BLK_WID - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(NBLK - 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CAM1, S_CAM2, S_DONE} state_t;

  state_t           state_q;
  logic             busy_q, done_q, err_q, cam1_start_q, cam2_start_q;
  logic [BLK_W-1:0] blk_idx_q;
  logic [RC_W-1:0]  row_q, col_q;
  logic [WD_W-1:0]  wdog_q;

  // Read port is decoded from state so rd_ready never feeds back into rd_valid.
  assign rd_valid_o  = (state_q == S_LOAD);
  assign rd_last_o   = rd_valid_o && (row_q == RC_MAX) && (col_q == RC_MAX);
  assign rd_addr_x_o = ADDR_W'(int'(blk_idx_q) * BLK_WID + int'(col_q));
  assign rd_addr_y_o = ADDR_W'(int'(blk_idx_q) * BLK_WID + int'(row_q));

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign blk_idx_o    = blk_idx_q;
  assign cam1_start_o = cam1_start_q;
  assign cam2_start_o = cam2_start_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cam1_start_q <= 1'b0;
      cam2_start_q <= 1'b0;
      blk_idx_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      wdog_q       <= '0;
    end else if (abort_i && state_q != S_IDLE) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cam1_start_q <= 1'b0;
      cam2_start_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state_q   <= S_LOAD;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            blk_idx_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
          end
        end
        S_LOAD: begin
          if (rd_ready_i) begin
            if (col_q == RC_MAX) begin
              col_q <= '0;
              if (row_q == RC_MAX) begin
                row_q        <= '0;
                state_q      <= S_CAM1;
                cam1_start_q <= 1'b1;
                wdog_q       <= '0;
              end else begin
                row_q <= row_q + RC_W'(1);
              end
            end else begin
              col_q <= col_q + RC_W'(1);
            end
          end
        end
        S_CAM1: begin
          cam1_start_q <= 1'b0;
          // done is only trusted after the launch cycle; it beats a same-cycle timeout
          if (!cam1_start_q && cam1_done_i) begin
            state_q      <= S_CAM2;
            cam2_start_q <= 1'b1;
            wdog_q       <= '0;
          end else if (wdog_q == WD_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_CAM2: begin
          cam2_start_q <= 1'b0;
          if (!cam2_start_q && cam2_done_i) begin
            if (blk_idx_q == BLK_MAX) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              blk_idx_q <= blk_idx_q + BLK_W'(1);
              state_q   <= S_LOAD;
            end
          end else if (wdog_q == WD_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sasa_block_scheduler.sv
// tb/tb_sasa_block_scheduler.sv - directed scenario bench for sasa_block_scheduler
// Watchdog shortened to 8 cycles so the timeout scenario stays brief.
module tb_sasa_block_scheduler;
  localparam int SEQ_LEN = 16;
  localparam int BLK_WID = 4;
  localparam int TIMEOUT = 8;
  localparam int ADDR_W  = 4;
  localparam int BLK_W   = 2;

  logic clk = 1'b0;
  logic reset, start, abort, rd_ready, cam1_done, cam2_done;
  logic busy, done, err, rd_valid, rd_last, cam1_start, cam2_start;
  logic [BLK_W-1:0]  blk_idx;
  logic [ADDR_W-1:0] rd_addr_x, rd_addr_y;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] log_x [128];
  logic [ADDR_W-1:0] log_y [128];
  logic              log_last [128];
  int r_beats, r_done, r_stall_bad, r_busy_at_done, r_busy_after_done;
  bit r_finished;

  always #5 clk = ~clk;

  sasa_block_scheduler #(
    .SEQ_LEN(SEQ_LEN), .BLK_WID(BLK_WID), .TIMEOUT(TIMEOUT),
    .ADDR_W(ADDR_W), .BLK_W(BLK_W)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .err_o(err), .blk_idx_o(blk_idx),
    .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_addr_x_o(rd_addr_x), .rd_addr_y_o(rd_addr_y), .rd_last_o(rd_last),
    .cam1_start_o(cam1_start), .cam1_done_i(cam1_done),
    .cam2_start_o(cam2_start), .cam2_done_i(cam2_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic abort_cleanup();
    rd_ready = 1'b0; cam1_done = 1'b0; cam2_done = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // Runs from the first LOAD cycle until busy drops; CAM phases answer 3 cycles after launch.
  task automatic drive_run(input bit rand_ready, input int budget);
    int c1, c2;
    bit stalled, prev_done;
    logic [ADDR_W-1:0] px, py;
    logic pl;
    c1 = 0; c2 = 0; stalled = 0; prev_done = 0; px = '0; py = '0; pl = 1'b0;
    r_beats = 0; r_done = 0; r_stall_bad = 0;
    r_busy_at_done = -1; r_busy_after_done = -1; r_finished = 0;
    for (int cyc = 0; cyc < budget && !r_finished; cyc++) begin
      if (prev_done) r_busy_after_done = int'(busy);
      prev_done = done;
      if (done) begin
        r_done++;
        r_busy_at_done = int'(busy);
      end
      if (!busy) begin
        r_finished = 1;
      end else begin
        if (stalled && (!rd_valid || rd_addr_x !== px || rd_addr_y !== py || rd_last !== pl))
          r_stall_bad++;
        if (cam1_start) begin c1 = 3; cam1_done = 1'b0; end
        else if (c1 > 0) begin c1--; cam1_done = (c1 == 0); end
        else cam1_done = 1'b0;
        if (cam2_start) begin c2 = 3; cam2_done = 1'b0; end
        else if (c2 > 0) begin c2--; cam2_done = (c2 == 0); end
        else cam2_done = 1'b0;
        rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd_valid && rd_ready) begin
          if (r_beats < 128) begin
            log_x[r_beats] = rd_addr_x;
            log_y[r_beats] = rd_addr_y;
            log_last[r_beats] = rd_last;
          end
          r_beats++;
        end
        stalled = rd_valid && !rd_ready;
        px = rd_addr_x; py = rd_addr_y; pl = rd_last;
        step();
      end
    end
    rd_ready = 1'b0; cam1_done = 1'b0; cam2_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if ({busy, done, err, rd_valid, rd_last, cam1_start, cam2_start} !== 7'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 0000000",
                      {busy, done, err, rd_valid, rd_last, cam1_start, cam2_start});
    end
    total++; if (blk_idx !== 2'd0) begin
      bad++; $display("FAIL reset_blk_idx: got %0d want 0", blk_idx);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_abort_idle();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      bad++; $display("FAIL abort_beats_start: got busy=%b rd_valid=%b want 0 0", busy, rd_valid);
    end
  endtask

  task automatic check_sequence(input string name);
    int seq_bad, first_k, lasts, ex, ey;
    seq_bad = 0; first_k = -1; lasts = 0;
    for (int k = 0; k < 64; k++) begin
      ex = (k / 16) * BLK_WID + (k % 16) % BLK_WID;
      ey = (k / 16) * BLK_WID + (k % 16) / BLK_WID;
      if (log_last[k]) lasts++;
      if (int'(log_x[k]) != ex || int'(log_y[k]) != ey || log_last[k] !== ((k % 16) == 15)) begin
        seq_bad++;
        if (first_k < 0) first_k = k;
      end
    end
    total++; if (seq_bad != 0) begin
      bad++; $display("FAIL %s_beat_order: %0d wrong beats, first at %0d got (%0d,%0d,last=%b) want 0 wrong",
                      name, seq_bad, first_k, log_x[first_k], log_y[first_k], log_last[first_k]);
    end
    total++; if (lasts != 4) begin
      bad++; $display("FAIL %s_last_count: got %0d want 4", name, lasts);
    end
  endtask

  task automatic test_nominal();
    pulse_start();
    drive_run(1'b0, 400);
    total++; if (!r_finished) begin
      bad++; $display("FAIL nominal_finish: got unfinished want finished");
    end
    total++; if (r_beats != 64) begin
      bad++; $display("FAIL nominal_beats: got %0d want 64", r_beats);
    end
    if (r_beats >= 64) check_sequence("nominal");
    total++; if (r_done != 1) begin
      bad++; $display("FAIL nominal_done_count: got %0d want 1", r_done);
    end
    total++; if (r_busy_at_done != 1 || r_busy_after_done != 0) begin
      bad++; $display("FAIL nominal_busy_fall: got at_done=%0d after=%0d want 1 0",
                      r_busy_at_done, r_busy_after_done);
    end
    total++; if (err !== 1'b0) begin
      bad++; $display("FAIL nominal_err: got %b want 0", err);
    end
  endtask

  task automatic test_backpressure();
    pulse_start();
    drive_run(1'b1, 800);
    total++; if (r_beats != 64) begin
      bad++; $display("FAIL bp_beats: got %0d want 64", r_beats);
    end
    if (r_beats >= 64) check_sequence("bp");
    total++; if (r_stall_bad != 0) begin
      bad++; $display("FAIL bp_stall_stable: got %0d changes want 0", r_stall_bad);
    end
    total++; if (r_done != 1) begin
      bad++; $display("FAIL bp_done_count: got %0d want 1", r_done);
    end
  endtask

  task automatic test_early_done();
    int c1, c2;
    c1 = -1; c2 = -1;
    pulse_start();
    rd_ready = 1'b1;
    for (int c = 0; c < 60 && c2 < 0; c++) begin
      if (cam1_start && c1 < 0) c1 = c;
      if (cam2_start) c2 = c;
      cam1_done = (c1 >= 0) && (c == c1 || c == c1 + 5);
      if (c2 < 0) step();
    end
    total++; if (c1 < 0 || c2 - c1 != 6) begin
      bad++; $display("FAIL early_done_cam2_entry: got %0d cycles after cam1_start want 6", c2 - c1);
    end
    abort_cleanup();
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL early_done_abort_cam2: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_timeout();
    int c1, c2;
    bit saw_done;
    logic busy7, err7, busy8, err8;
    c1 = 0; c2 = -1; saw_done = 0;
    busy7 = 1'bx; err7 = 1'bx; busy8 = 1'bx; err8 = 1'bx;
    pulse_start();
    rd_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (done) saw_done = 1;
      if (cam2_start && c2 < 0) c2 = c;
      if (c2 >= 0 && c == c2 + 7) begin busy7 = busy; err7 = err; end
      if (c2 >= 0 && c == c2 + 8) begin busy8 = busy; err8 = err; break; end
      if (cam1_start) begin c1 = 3; cam1_done = 1'b0; end
      else if (c1 > 0) begin c1--; cam1_done = (c1 == 0); end
      else cam1_done = 1'b0;
      step();
    end
    rd_ready = 1'b0; cam1_done = 1'b0;
    total++; if (busy7 !== 1'b1 || err7 !== 1'b0) begin
      bad++; $display("FAIL timeout_cycle8: got busy=%b err=%b want 1 0", busy7, err7);
    end
    total++; if (busy8 !== 1'b0 || err8 !== 1'b1) begin
      bad++; $display("FAIL timeout_after8: got busy=%b err=%b want 0 1", busy8, err8);
    end
    total++; if (saw_done) begin
      bad++; $display("FAIL timeout_no_done: got done pulse want none");
    end
    step();
    total++; if (err !== 1'b1) begin
      bad++; $display("FAIL timeout_err_sticky: got %b want 1", err);
    end
    pulse_start();
    total++; if (err !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_restart_clears: got err=%b busy=%b want 0 1", err, busy);
    end
    abort_cleanup();
  endtask

  task automatic test_abort_load();
    int c1, c2, beats;
    bit hit;
    c1 = 0; c2 = 0; beats = 0; hit = 0;
    pulse_start();
    rd_ready = 1'b1;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (rd_valid && beats == 37) begin
        hit = 1;
        total++; if (rd_addr_x !== 4'd9 || rd_addr_y !== 4'd9 || blk_idx !== 2'd2) begin
          bad++; $display("FAIL abort_beat5_addr: got (%0d,%0d) blk=%0d want (9,9) blk=2",
                          rd_addr_x, rd_addr_y, blk_idx);
        end
        abort = 1'b1;
      end else if (rd_valid) begin
        beats++;
      end
      if (cam1_start) begin c1 = 3; cam1_done = 1'b0; end
      else if (c1 > 0) begin c1--; cam1_done = (c1 == 0); end
      else cam1_done = 1'b0;
      if (cam2_start) begin c2 = 3; cam2_done = 1'b0; end
      else if (c2 > 0) begin c2--; cam2_done = (c2 == 0); end
      else cam2_done = 1'b0;
      step();
    end
    abort = 1'b0; rd_ready = 1'b0; cam1_done = 1'b0; cam2_done = 1'b0;
    total++; if (!hit) begin
      bad++; $display("FAIL abort_reach_block2: got no beat 37 want reached");
    end
    total++; if (busy !== 1'b0 || rd_valid !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b rd_valid=%b err=%b done=%b want 0 0 0 0",
                      busy, rd_valid, err, done);
    end
    pulse_start();
    total++; if (rd_valid !== 1'b1 || rd_addr_x !== 4'd0 || rd_addr_y !== 4'd0 || blk_idx !== 2'd0) begin
      bad++; $display("FAIL abort_restart_first: got v=%b (%0d,%0d) blk=%0d want 1 (0,0) 0",
                      rd_valid, rd_addr_x, rd_addr_y, blk_idx);
    end
    abort_cleanup();
  endtask

  task automatic test_reset_mid_cam1();
    bit seen;
    seen = 0;
    pulse_start();
    rd_ready = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (cam1_start) seen = 1;
      step();
    end
    rd_ready = 1'b0;
    total++; if (!seen) begin
      bad++; $display("FAIL rst_mid_reach_cam1: got no cam1_start want seen");
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if ({busy, done, err, rd_valid, rd_last, cam1_start, cam2_start} !== 7'b0 || blk_idx !== 2'd0) begin
      bad++; $display("FAIL rst_mid_outputs: got %b blk=%0d want 0000000 blk=0",
                      {busy, done, err, rd_valid, rd_last, cam1_start, cam2_start}, blk_idx);
    end
    pulse_start();
    drive_run(1'b0, 400);
    total++; if (r_beats != 64 || r_done != 1) begin
      bad++; $display("FAIL rst_mid_rerun: got beats=%0d done=%0d want 64 1", r_beats, r_done);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    rd_ready = 1'b0; cam1_done = 1'b0; cam2_done = 1'b0;
    test_reset();
    test_abort_idle();
    test_nominal();
    test_backpressure();
    test_early_done();
    test_timeout();
    test_abort_load();
    test_reset_mid_cam1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
